eq_band_scheduler: RTL and testbench

- Sequences a cascade of NB biquad band filters, each an independent Filtro-type section with its own state registers, through one shared input bus, one section per clock cycle.
- Inserts a register between sections, which breaks the long combinational yk->uk chain of a direct cascade.
- Accepts one audio sample per sample strobe and advances each non-bypassed band's state exactly once per sample.
- Presents the equalized sample on a valid/ready output; sits between the codec sample interface and the output path.

---
 rtl/eq_pkg.sv | 21 ++
 rtl/eq_band_scheduler_sat_counter.sv | 29 ++
 rtl/eq_band_scheduler.sv | 138 +++++++++++++
 tb/tb_eq_band_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the EQ band scheduler.
// Contents:
//   state_t    - scheduler FSM state encoding (IDLE / RUN / OUT)
//   P_DEF      - default integer bits of the Q(p.f) sample format
//   F_DEF      - default fractional bits
//   WIDTH_DEF  - default sample width, 1 + P_DEF + F_DEF
//   ONE        - the Q(p.f) value 1.0 (2^F_DEF), used for unity coefficients
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int P_DEF     = 4;
    localparam int F_DEF     = 13;
    localparam int WIDTH_DEF = 1 + P_DEF + F_DEF;
    localparam int ONE       = 1 << F_DEF;

endpackage

// File: rtl/eq_band_scheduler_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - add one this cycle (ignored once the count is all ones)
//   count - current count, holds at 2^CW-1 instead of wrapping
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] cnt_r;

    // Count register: steps on inc until every bit is set, then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != {CW{1'b1}})) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign count = cnt_r;

endmodule

// File: rtl/eq_band_scheduler.sv
// Time-multiplexed scheduler for a cascade of NB biquad band filters.
// Each accepted sample is carried in acc and visited through the bands one
// per clock: the band's input is the registered acc, and its output is
// captured back into acc on the same edge that advances the band's state.
// Registering between bands removes the long combinational chain of a
// direct cascade.
// Ports:
//   sclk       - system clock, rising edge
//   rst        - asynchronous active-low reset (shared with the band filters)
//   in_strobe  - one-cycle sample-valid pulse, cannot be back-pressured
//   in_sample  - signed input sample
//   bypass     - per-band bypass, bit i sampled while band i is visited
//   band_uk    - shared input bus to every band
//   band_en    - one-hot state-advance enable per band
//   band_yk    - packed band outputs, band i at [i*Width +: Width]
//   out_valid  - out_sample valid
//   out_ready  - downstream accepts out_sample
//   out_sample - equalized sample
//   busy       - high while a sample is in RUN or OUT
//   band_idx   - band currently visited (0 outside RUN)
//   drop_cnt   - saturating count of strobes lost while busy
module eq_band_scheduler
    import eq_pkg::*;
#(
    parameter int NB    = 4,
    parameter int p     = P_DEF,
    parameter int f     = F_DEF,
    parameter int Width = 1 + p + f,
    parameter int CW    = 8,
    parameter int IW    = $clog2(NB)
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  in_strobe,
    input  logic [Width-1:0]      in_sample,
    input  logic [NB-1:0]         bypass,
    output logic [Width-1:0]      band_uk,
    output logic [NB-1:0]         band_en,
    input  logic [NB*Width-1:0]   band_yk,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Width-1:0]      out_sample,
    output logic                  busy,
    output logic [IW-1:0]         band_idx,
    output logic [CW-1:0]         drop_cnt
);

    state_t           state_r;
    state_t           state_next_s;
    logic [Width-1:0] acc_r;
    logic [Width-1:0] acc_next_s;
    logic [IW-1:0]    idx_r;
    logic [IW-1:0]    idx_next_s;
    logic [NB-1:0]    band_en_s;
    logic [Width-1:0] yk_sel_s;
    logic             drop_inc_s;

    assign yk_sel_s = band_yk[idx_r*Width +: Width];

    // State, accumulator and band index registers.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            acc_r   <= {Width{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else begin
            state_r <= state_next_s;
            acc_r   <= acc_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state logic and band enable; enable is only ever raised in RUN,
    // so each band advances at most once per accepted sample.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        idx_next_s   = idx_r;
        band_en_s    = {NB{1'b0}};
        drop_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_strobe) begin
                    acc_next_s   = in_sample;
                    idx_next_s   = {IW{1'b0}};
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                drop_inc_s = in_strobe;
                if (!bypass[idx_r]) begin
                    band_en_s[idx_r] = 1'b1;
                    acc_next_s       = yk_sel_s;
                end else begin
                    acc_next_s = acc_r;
                end
                if (idx_r == IW'(NB - 1)) begin
                    idx_next_s   = {IW{1'b0}};
                    state_next_s = OUT;
                end else begin
                    idx_next_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            OUT: begin
                // A strobe coinciding with the handshake is still dropped.
                drop_inc_s = in_strobe;
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = {IW{1'b0}};
            end
        endcase
    end

    sat_counter #(
        .CW(CW)
    ) u_drop_cnt (
        .clk  (sclk),
        .rst_n(rst),
        .inc  (drop_inc_s),
        .count(drop_cnt)
    );

    assign band_uk    = acc_r;
    assign band_en    = band_en_s;
    assign band_idx   = idx_r;
    assign out_valid  = (state_r == OUT);
    assign out_sample = acc_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed bench for eq_band_scheduler with four behavioural band filters
// (gain-only sections, coefficient b0 in Q4.13, per-band state registers).
// A second instance with CW=2 exercises drop counter saturation.
module tb_eq_band_scheduler;
    import eq_pkg::*;

    localparam int NB = 4;
    localparam int W  = WIDTH_DEF;

    logic              sclk = 1'b0;
    logic              rst  = 1'b0;
    logic              in_strobe;
    logic [W-1:0]      in_sample;
    logic [NB-1:0]     bypass;
    logic [W-1:0]      band_uk;
    logic [NB-1:0]     band_en;
    logic [NB*W-1:0]   band_yk;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_sample;
    logic              busy;
    logic [1:0]        band_idx;
    logic [7:0]        drop_cnt;

    logic              strobe2;
    logic              ready2;
    logic [W-1:0]      band_uk2;
    logic [NB-1:0]     band_en2;
    logic              out_valid2;
    logic [W-1:0]      out_sample2;
    logic              busy2;
    logic [1:0]        band_idx2;
    logic [1:0]        drop_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    eq_band_scheduler #(.NB(NB), .CW(8)) dut (
        .sclk(sclk), .rst(rst), .in_strobe(in_strobe), .in_sample(in_sample),
        .bypass(bypass), .band_uk(band_uk), .band_en(band_en), .band_yk(band_yk),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .busy(busy), .band_idx(band_idx), .drop_cnt(drop_cnt)
    );

    eq_band_scheduler #(.NB(NB), .CW(2)) dut2 (
        .sclk(sclk), .rst(rst), .in_strobe(strobe2), .in_sample(in_sample),
        .bypass(4'b1111), .band_uk(band_uk2), .band_en(band_en2), .band_yk({(NB*W){1'b0}}),
        .out_valid(out_valid2), .out_ready(ready2), .out_sample(out_sample2),
        .busy(busy2), .band_idx(band_idx2), .drop_cnt(drop_cnt2)
    );

    // Band filter model: yk = sat((b0 * uk) >>> 13), state loads on enable.
    logic signed [W-1:0] b0 [NB];
    logic [W-1:0]        x1 [NB];
    logic [W-1:0]        y1 [NB];
    logic [W-1:0]        x1_snap [NB];

    function automatic logic [W-1:0] band_fn(logic signed [W-1:0] c, logic signed [W-1:0] u);
        logic signed [2*W-1:0] pr;
        pr = c * u;
        pr = pr >>> 13;
        if (pr > 36'sd131071)
            return 18'h1FFFF;
        else if (pr < -36'sd131072)
            return 18'h20000;
        else
            return pr[W-1:0];
    endfunction

    always_comb begin
        band_yk = '0;
        for (int i = 0; i < NB; i++)
            band_yk[i*W +: W] = band_fn(b0[i], band_uk);
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                x1[i] <= '0;
                y1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (band_en[i]) begin
                    x1[i] <= band_uk;
                    y1[i] <= band_yk[i*W +: W];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic set_b0(input logic [W-1:0] v);
        for (int i = 0; i < NB; i++) b0[i] = v;
    endtask

    logic [NB-1:0] seen;
    logic [1:0]    exp_sat [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        in_strobe = 1'b0; in_sample = '0; bypass = '0; out_ready = 1'b1;
        strobe2 = 1'b0; ready2 = 1'b0;
        set_b0(18'h02000);
        repeat (2) step();
        check("rst_band_en", band_en, 4'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_cnt, 8'd0);
        check("rst_idx", band_idx, 2'd0);
        check("rst_out_sample", out_sample, 18'h0);
        check("rst_band_uk", band_uk, 18'h0);
        rst = 1'b1;
        step();
        check("idle_after_release_en", band_en, 4'h0);

        // Identity coefficients
        in_sample = 18'h01000; in_strobe = 1'b1;
        step();
        in_strobe = 1'b0;
        check("id_uk0", band_uk, 18'h01000);
        check("id_en0", band_en, 4'b0001);
        check("id_idx0", band_idx, 2'd0);
        step(); check("id_en1", band_en, 4'b0010); check("id_idx1", band_idx, 2'd1);
        step(); check("id_en2", band_en, 4'b0100);
        step(); check("id_en3", band_en, 4'b1000); check("id_idx3", band_idx, 2'd3);
        step();
        check("id_valid", out_valid, 1'b1);
        check("id_out", out_sample, 18'h01000);
        check("id_drop", drop_cnt, 8'd0);
        step();
        check("id_done_valid", out_valid, 1'b0);
        check("id_done_busy", busy, 1'b0);

        // Gain 2 with band 1 bypassed
        set_b0(18'h04000); bypass = 4'b0010;
        in_sample = 18'h00200; in_strobe = 1'b1;
        step();
        in_strobe = 1'b0; seen = '0;
        for (int i = 0; i < NB; i++) begin seen |= band_en; step(); end
        check("gain_seen", seen, 4'b1101);
        check("gain_valid", out_valid, 1'b1);
        check("gain_out", out_sample, 18'h01000);
        step();

        // All bands bypassed
        set_b0(18'h02000); bypass = 4'b1111;
        for (int i = 0; i < NB; i++) x1_snap[i] = x1[i];
        in_sample = 18'h3FFFB; in_strobe = 1'b1;
        step();
        in_strobe = 1'b0; seen = '0;
        for (int i = 0; i < NB; i++) begin seen |= band_en; step(); end
        check("byp_seen", seen, 4'b0000);
        check("byp_out", out_sample, 18'h3FFFB);
        for (int i = 0; i < NB; i++) check("byp_state", x1[i], x1_snap[i]);
        step();

        // Backpressure with three dropped strobes
        bypass = 4'b0000; out_ready = 1'b0;
        in_sample = 18'h01000; in_strobe = 1'b1;
        step();
        in_strobe = 1'b0;
        repeat (4) step();
        check("bp_valid", out_valid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            in_strobe = (c == 1 || c == 4 || c == 7);
            in_sample = 18'h00777;
            step();
            in_strobe = 1'b0;
            check("bp_hold", out_sample, 18'h01000);
            check("bp_busy", busy, 1'b1);
        end
        check("bp_drop", drop_cnt, 8'd3);
        out_ready = 1'b1;
        step();
        check("bp_rel_valid", out_valid, 1'b0);
        check("bp_rel_busy", busy, 1'b0);
        in_sample = 18'h00800; in_strobe = 1'b1;
        step();
        in_strobe = 1'b0;
        check("bp_next_busy", busy, 1'b1);
        check("bp_next_uk", band_uk, 18'h00800);
        repeat (4) step();
        check("bp_next_out", out_sample, 18'h00800);
        step();

        // Asynchronous reset mid-sample
        in_sample = 18'h01000; in_strobe = 1'b1;
        step();
        in_strobe = 1'b0;
        step(); step();
        check("ar_idx", band_idx, 2'd2);
        #2 rst = 1'b0;
        #1;
        check("ar_en", band_en, 4'h0);
        check("ar_valid", out_valid, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_drop", drop_cnt, 8'd0);
        check("ar_idx0", band_idx, 2'd0);
        step();
        rst = 1'b1;
        step();
        in_strobe = 1'b1;
        step();
        in_strobe = 1'b0;
        repeat (4) step();
        check("ar_after_valid", out_valid, 1'b1);
        check("ar_after_out", out_sample, 18'h01000);
        step();

        // CW=2 saturation while held in OUT
        strobe2 = 1'b1;
        step();
        strobe2 = 1'b0;
        repeat (4) step();
        check("sat_valid", out_valid2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            strobe2 = 1'b1;
            step();
            check("sat_cnt", drop_cnt2, exp_sat[k]);
        end
        strobe2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
